// File: rtl/pipeline_pkg.sv
// Shared RV32I pipeline definitions: ALU op codes, forwarding selects and datapath widths.
// Decode, the hazard unit and the execute stage all import this package.
package pipeline_pkg;

   localparam int XLEN_DEF = 32;
   localparam int REGW_DEF = 5;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX pipeline register bundle: decode drives it (master), execute consumes it (slave).
interface execute_stage_if
   import pipeline_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int REGW = REGW_DEF
) ();

   logic            RegwriteE;
   logic            MemwriteE;
   logic            JumpE;
   logic            branchE;
   logic            ALUSrcE;
   logic [1:0]      ResultSrcE;
   logic [3:0]      ALUControlE;
   logic [XLEN-1:0] RD1E;
   logic [XLEN-1:0] RD2E;
   logic [XLEN-1:0] immExtE;
   logic [XLEN-1:0] PCE;
   logic [XLEN-1:0] pc_plus4E;
   logic [REGW-1:0] RdE;
   logic [REGW-1:0] Rs1E;
   logic [REGW-1:0] Rs2E;

   modport master (
      output RegwriteE, MemwriteE, JumpE, branchE, ALUSrcE, ResultSrcE, ALUControlE,
             RD1E, RD2E, immExtE, PCE, pc_plus4E, RdE, Rs1E, Rs2E
   );

   modport slave (
      input RegwriteE, MemwriteE, JumpE, branchE, ALUSrcE, ResultSrcE, ALUControlE,
            RD1E, RD2E, immExtE, PCE, pc_plus4E, RdE, Rs1E, Rs2E
   );

endinterface

// File: rtl/alu.sv
// Combinational RV32I ALU; shift amount is the low five bits of SrcB, unknown ops yield zero.
module alu
   import pipeline_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [XLEN-1:0] SrcA,
   input  logic [XLEN-1:0] SrcB,
   input  logic [3:0]      ALUControl,
   output logic [XLEN-1:0] Result,
   output logic            Zero
);

   logic [4:0] shamt;
   assign shamt = SrcB[4:0];

   always_comb begin
      // NOTE: default assigned first so every path drives Result and no latch is inferred.
      Result = '0;
      case (ALUControl)
         ALU_ADD:  Result = SrcA + SrcB;
         ALU_SUB:  Result = SrcA - SrcB;
         ALU_AND:  Result = SrcA & SrcB;
         ALU_OR:   Result = SrcA | SrcB;
         ALU_XOR:  Result = SrcA ^ SrcB;
         ALU_SLT:  Result = {{(XLEN-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
         ALU_SLTU: Result = {{(XLEN-1){1'b0}}, SrcA < SrcB};
         ALU_SLL:  Result = SrcA << shamt;
         ALU_SRL:  Result = SrcA >> shamt;
         ALU_SRA:  Result = $signed(SrcA) >>> shamt;
         default:  Result = '0;
      endcase
   end

   assign Zero = (Result == '0);

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, beq/jump redirect and the EX/MEM register,
// which holds while the cache controller stalls the memory side.
module execute_stage
   import pipeline_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int REGW = REGW_DEF
) (
   input  logic            clk,
   input  logic            rst,
   execute_stage_if.slave  idEx,
   input  logic [1:0]      ForwardAE,
   input  logic [1:0]      ForwardBE,
   input  logic [XLEN-1:0] ResultW,
   input  logic            StallE,
   output logic            PCSrcE,
   output logic [XLEN-1:0] PCTargetE,
   output logic            RegwriteM,
   output logic            MemwriteM,
   output logic [1:0]      ResultSrcM,
   output logic [XLEN-1:0] ALUResultM,
   output logic [XLEN-1:0] WriteDataM,
   output logic [XLEN-1:0] pc_plus4M,
   output logic [REGW-1:0] RdM
);

   typedef struct packed {
      logic            regwrite;
      logic            memwrite;
      logic [1:0]      resultSrc;
      logic [XLEN-1:0] aluResult;
      logic [XLEN-1:0] writeData;
      logic [XLEN-1:0] pcPlus4;
      logic [REGW-1:0] rd;
   } exMem_t;

   exMem_t          exMemD, exMemQ, exMemOut;
   logic [XLEN-1:0] SrcAE, SrcBE, WriteDataE, ALUResultE;
   logic            ZeroE;

   // Select code 11 is unused by the hazard unit and falls back to the register value.
   function automatic logic [XLEN-1:0] fwdSel(input logic [1:0]      sel,
                                              input logic [XLEN-1:0] regVal,
                                              input logic [XLEN-1:0] wbVal,
                                              input logic [XLEN-1:0] memVal);
      case (sel)
         FWD_WB:  return wbVal;
         FWD_MEM: return memVal;
         default: return regVal;
      endcase
   endfunction

   assign SrcAE      = fwdSel(ForwardAE, idEx.RD1E, ResultW, ALUResultM);
   assign WriteDataE = fwdSel(ForwardBE, idEx.RD2E, ResultW, ALUResultM);
   assign SrcBE      = idEx.ALUSrcE ? idEx.immExtE : WriteDataE;

   alu #(.XLEN(XLEN)) uAlu (
      .SrcA       (SrcAE),
      .SrcB       (SrcBE),
      .ALUControl (idEx.ALUControlE),
      .Result     (ALUResultE),
      .Zero       (ZeroE)
   );

   // Only beq is resolved here; the hazard unit qualifies the redirect during a stall.
   assign PCTargetE = idEx.PCE + idEx.immExtE;
   assign PCSrcE    = rst & (idEx.JumpE | (idEx.branchE & ZeroE));

   assign exMemD = '{
      regwrite:  idEx.RegwriteE,
      memwrite:  idEx.MemwriteE,
      resultSrc: idEx.ResultSrcE,
      aluResult: ALUResultE,
      writeData: WriteDataE,
      pcPlus4:   idEx.pc_plus4E,
      rd:        idEx.RdE
   };

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: non-blocking assignments for state; this pipeline register is small logic,
      // not a memory, so every field is cleared by the asynchronous reset.
      if (!rst) begin
         exMemQ <= '0;
      end else if (!StallE) begin
         exMemQ <= exMemD;
      end
   end

   // Outputs also read zero for as long as reset is held, not just after the clearing edge.
   assign exMemOut   = rst ? exMemQ : '0;
   assign RegwriteM  = exMemOut.regwrite;
   assign MemwriteM  = exMemOut.memwrite;
   assign ResultSrcM = exMemOut.resultSrc;
   assign ALUResultM = exMemOut.aluResult;
   assign WriteDataM = exMemOut.writeData;
   assign pc_plus4M  = exMemOut.pcPlus4;
   assign RdM        = exMemOut.rd;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: stimulus queues hand-computed expectations,
// a monitor pops and compares them once the DUT outputs are due.
module tb_execute_stage;
   import pipeline_pkg::*;

   localparam int XLEN = 32;
   localparam int REGW = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   execute_stage_if #(.XLEN(XLEN), .REGW(REGW)) idEx ();

   logic [1:0]      ForwardAE, ForwardBE;
   logic [XLEN-1:0] ResultW;
   logic            StallE;
   logic            PCSrcE;
   logic [XLEN-1:0] PCTargetE;
   logic            RegwriteM, MemwriteM;
   logic [1:0]      ResultSrcM;
   logic [XLEN-1:0] ALUResultM, WriteDataM, pc_plus4M;
   logic [REGW-1:0] RdM;

   execute_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
      .clk        (clk),
      .rst        (rst),
      .idEx       (idEx.slave),
      .ForwardAE  (ForwardAE),
      .ForwardBE  (ForwardBE),
      .ResultW    (ResultW),
      .StallE     (StallE),
      .PCSrcE     (PCSrcE),
      .PCTargetE  (PCTargetE),
      .RegwriteM  (RegwriteM),
      .MemwriteM  (MemwriteM),
      .ResultSrcM (ResultSrcM),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .pc_plus4M  (pc_plus4M),
      .RdM        (RdM)
   );

   typedef struct {
      logic        regw, memw, jump, branch, aluSrc, stall;
      logic [1:0]  resSrc, fa, fb;
      logic [3:0]  op;
      logic [31:0] rd1, rd2, imm, pc, pc4, resW;
      logic [4:0]  rd;
   } vec_t;

   typedef struct {
      string       name;
      int          due;
      logic        pcSrc;
      logic [31:0] target;
      logic [8:0]  ctl;
      logic [31:0] alu, wd, pc4;
   } exp_t;

   exp_t sb[$];
   exp_t heldM;
   int   cycle = 0;
   int   nCompared = 0;
   int   nMismatched = 0;
   event sampleEv;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      nCompared++;
      if (act !== req) begin
         nMismatched++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
      end
   endtask

   function automatic vec_t zv();
      vec_t r;
      r = '{default: '0};
      return r;
   endfunction

   task automatic apply(input vec_t v);
      idEx.RegwriteE   = v.regw;
      idEx.MemwriteE   = v.memw;
      idEx.JumpE       = v.jump;
      idEx.branchE     = v.branch;
      idEx.ALUSrcE     = v.aluSrc;
      idEx.ResultSrcE  = v.resSrc;
      idEx.ALUControlE = v.op;
      idEx.RD1E        = v.rd1;
      idEx.RD2E        = v.rd2;
      idEx.immExtE     = v.imm;
      idEx.PCE         = v.pc;
      idEx.pc_plus4E   = v.pc4;
      idEx.RdE         = v.rd;
      idEx.Rs1E        = 5'd1;
      idEx.Rs2E        = 5'd2;
      ForwardAE        = v.fa;
      ForwardBE        = v.fb;
      ResultW          = v.resW;
      StallE           = v.stall;
   endtask

   // Drive one ID/EX vector; the expectation is due after the next rising edge.
   task automatic issue(input vec_t v, input logic [31:0] alu, input logic [31:0] wd,
                        input logic pcSrc, input logic [31:0] tgt, input string name);
      exp_t e;
      @(negedge clk);
      #1;
      rst = 1'b1;
      apply(v);
      if (!v.stall) begin
         heldM.ctl = {v.regw, v.memw, v.resSrc, v.rd};
         heldM.alu = alu;
         heldM.wd  = wd;
         heldM.pc4 = v.pc4;
      end
      e        = heldM;
      e.name   = name;
      e.due    = cycle + 1;
      e.pcSrc  = pcSrc;
      e.target = tgt;
      sb.push_back(e);
   endtask

   // Assert reset mid-cycle and sample straight away: outputs must clear without a clock edge.
   task automatic doReset(input vec_t v, input logic [31:0] tgt, input string name);
      exp_t e;
      @(negedge clk);
      #1;
      rst = 1'b0;
      apply(v);
      #1;
      heldM    = '{name: "", due: 0, pcSrc: 1'b0, target: '0, ctl: '0, alu: '0, wd: '0, pc4: '0};
      e        = heldM;
      e.name   = name;
      e.due    = cycle;
      e.target = tgt;
      sb.push_back(e);
      ->sampleEv;
   endtask

   exp_t mon;
   initial begin
      forever begin
         @(negedge clk or sampleEv);
         while (sb.size() > 0 && sb[0].due <= cycle) begin
            mon = sb.pop_front();
            check({mon.name, ".PCSrcE"},     {31'd0, PCSrcE}, {31'd0, mon.pcSrc});
            check({mon.name, ".PCTargetE"},  PCTargetE, mon.target);
            check({mon.name, ".ctlM"},       {23'd0, RegwriteM, MemwriteM, ResultSrcM, RdM},
                                             {23'd0, mon.ctl});
            check({mon.name, ".ALUResultM"}, ALUResultM, mon.alu);
            check({mon.name, ".WriteDataM"}, WriteDataM, mon.wd);
            check({mon.name, ".pc_plus4M"},  pc_plus4M, mon.pc4);
         end
      end
   end

   initial begin
      vec_t v;
      apply(zv());
      doReset(zv(), 32'h0, "resetInit");

      // Load with RegwriteM=1, then reset mid-run with a jump pending.
      v = zv(); v.regw = 1; v.memw = 1; v.resSrc = 2'd1; v.rd1 = 32'd5; v.rd2 = 32'h11;
      v.aluSrc = 1; v.imm = 32'd7; v.op = ALU_ADD; v.rd = 5'd3; v.pc = 32'h4; v.pc4 = 32'h8;
      issue(v, 32'd12, 32'h11, 1'b0, 32'hB, "loadA");
      v.jump = 1;
      doReset(v, 32'hB, "midReset");

      v = zv(); v.rd1 = 32'd5; v.imm = 32'd7; v.aluSrc = 1; v.op = ALU_ADD; v.rd = 5'd4; v.pc4 = 32'hC;
      issue(v, 32'd12, 32'd0, 1'b0, 32'd7, "afterReset");

      // Forwarding.
      v = zv(); v.rd1 = 32'h10; v.op = ALU_ADD; v.rd = 5'd5; v.regw = 1;
      issue(v, 32'h10, 32'd0, 1'b0, 32'd0, "fwdPrep");
      v = zv(); v.rd1 = 32'd1; v.fa = FWD_MEM; v.rd2 = 32'd3; v.fb = FWD_WB; v.resW = 32'h20;
      v.op = ALU_SUB; v.resSrc = 2'd2; v.rd = 5'd6; v.regw = 1;
      issue(v, 32'hFFFF_FFF0, 32'h20, 1'b0, 32'd0, "fwdMemWb");
      v = zv(); v.rd1 = 32'd7; v.fa = 2'b11; v.rd2 = 32'd2; v.fb = 2'b11; v.resW = 32'h99; v.op = ALU_ADD;
      issue(v, 32'd9, 32'd2, 1'b0, 32'd0, "fwd11");
      v = zv(); v.fa = FWD_WB; v.resW = 32'h30; v.fb = FWD_MEM; v.op = ALU_SUB;
      issue(v, 32'h27, 32'd9, 1'b0, 32'd0, "fwdWbMem");

      // Branch (beq via sub).
      v = zv(); v.branch = 1; v.rd1 = 32'd9; v.rd2 = 32'd9; v.op = ALU_SUB; v.pc = 32'h100;
      v.imm = 32'hFFFF_FFF8;
      issue(v, 32'd0, 32'd9, 1'b1, 32'hF8, "beqTaken");
      v.rd2 = 32'd8;
      issue(v, 32'd1, 32'd8, 1'b0, 32'hF8, "beqNotTaken");

      // Stall holds EX/MEM while combinational outputs track.
      v = zv(); v.rd1 = 32'h55; v.op = ALU_ADD; v.rd = 5'd7; v.regw = 1; v.resSrc = 2'd2; v.pc4 = 32'h70;
      issue(v, 32'h55, 32'd0, 1'b0, 32'd0, "stallPrep");
      v = zv(); v.rd1 = 32'd1; v.rd2 = 32'd1; v.op = ALU_ADD; v.rd = 5'd9; v.regw = 1; v.memw = 1;
      v.jump = 1; v.pc = 32'h200; v.imm = 32'h10; v.stall = 1;
      for (int i = 0; i < 3; i++) issue(v, 32'd0, 32'd0, 1'b1, 32'h210, $sformatf("stall%0d", i));
      v.stall = 0;
      issue(v, 32'd2, 32'd1, 1'b1, 32'h210, "unstall");

      // ALU corners.
      v = zv(); v.rd1 = 32'h8000_0000; v.imm = 32'd4; v.aluSrc = 1; v.op = ALU_SRA;
      issue(v, 32'hF800_0000, 32'd0, 1'b0, 32'd4, "sra");
      v.op = ALU_SRL;
      issue(v, 32'h0800_0000, 32'd0, 1'b0, 32'd4, "srl");
      v = zv(); v.rd1 = 32'hFFFF_FFFF; v.rd2 = 32'd1; v.op = ALU_SLT;
      issue(v, 32'd1, 32'd1, 1'b0, 32'd0, "slt");
      v.op = ALU_SLTU;
      issue(v, 32'd0, 32'd1, 1'b0, 32'd0, "sltu");
      v = zv(); v.rd1 = 32'd1; v.rd2 = 32'hFFFF_FFFF; v.op = ALU_SLT;
      issue(v, 32'd0, 32'hFFFF_FFFF, 1'b0, 32'd0, "sltRev");
      v.op = ALU_SLTU;
      issue(v, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'd0, "sltuRev");
      v = zv(); v.rd1 = 32'd3; v.imm = 32'h21; v.aluSrc = 1; v.op = ALU_SLL;
      issue(v, 32'd6, 32'd0, 1'b0, 32'h21, "sllWrap");
      v = zv(); v.rd1 = 32'hF0F0; v.rd2 = 32'hFF00; v.op = ALU_AND;
      issue(v, 32'hF000, 32'hFF00, 1'b0, 32'd0, "and");
      v.op = ALU_OR;
      issue(v, 32'hFFF0, 32'hFF00, 1'b0, 32'd0, "or");
      v.op = ALU_XOR;
      issue(v, 32'h0FF0, 32'hFF00, 1'b0, 32'd0, "xor");
      v = zv(); v.rd1 = 32'hFFFF_FFFF; v.rd2 = 32'd2; v.op = ALU_ADD;
      issue(v, 32'd1, 32'd2, 1'b0, 32'd0, "addWrap");
      v = zv(); v.rd1 = 32'd5; v.rd2 = 32'd5; v.op = 4'b1111;
      issue(v, 32'd0, 32'd5, 1'b0, 32'd0, "opUnused");

      // Jump.
      v = zv(); v.jump = 1; v.pc = 32'h40; v.imm = 32'h20; v.pc4 = 32'h44; v.aluSrc = 1; v.op = ALU_ADD;
      issue(v, 32'h20, 32'd0, 1'b1, 32'h60, "jump");

      repeat (3) @(negedge clk);
      #2;
      if (sb.size() != 0) begin
         nCompared++;
         nMismatched++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the five-stage RV32I pipeline, and the consumer of the ID/EX pipeline register that the decode stage drives. It applies the forwarding muxes and runs the ALU. It resolves branches and jumps, producing the fetch redirect. It owns the EX/MEM pipeline register, which holds under a memory-side stall from the cache controller and feeds the memory stage.

## Interface
Parameters:
- XLEN, 32, datapath width
- REGW, 5, register index width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- RegwriteE, MemwriteE, JumpE, branchE, ALUSrcE  in  1 each  ID/EX control
- ResultSrcE  in  2  result select, passed through
- ALUControlE  in  4  ALU op (encoding under Operation)
- RD1E, RD2E, immExtE, PCE, pc_plus4E  in  XLEN each  ID/EX data
- RdE, Rs1E, Rs2E  in  REGW each  register indices
- ForwardAE, ForwardBE  in  2 each  operand select from hazard unit
- ResultW  in  XLEN  writeback value for forwarding
- StallE  in  1  hold EX/MEM register (cache miss)
- PCSrcE  out  1  redirect fetch (combinational)
- PCTargetE  out  XLEN  redirect target (combinational)
- RegwriteM, MemwriteM  out  1 each  EX/MEM control
- ResultSrcM  out  2  EX/MEM result select
- ALUResultM, WriteDataM, pc_plus4M  out  XLEN each  EX/MEM data
- RdM  out  REGW  EX/MEM destination index

## Operation
- Operand forwarding: for ForwardXE, 00 selects the register value (RD1E or RD2E), 01 selects ResultW, 10 selects ALUResultM (the registered output), and 11 is treated as 00.
  - SrcAE is the forwarded A operand.
  - WriteDataE is the forwarded B operand.
  - SrcBE = ALUSrcE ? immExtE : WriteDataE.
- ALU op encoding:
  - 0000 add
  - 0001 sub
  - 0010 and
  - 0011 or
  - 0100 xor
  - 0101 slt (signed, result 0/1)
  - 0110 sltu
  - 0111 sll
  - 1000 srl
  - 1001 sra
  - any other code yields 0
- Shift amount is SrcBE[4:0].
- All arithmetic is modulo 2^XLEN; overflow is ignored.
- ZeroE = (ALUResultE == 0).
- PCTargetE = PCE + immExtE, mod 2^XLEN.
- PCSrcE = rst & (JumpE | (branchE & ZeroE)). Only beq semantics are supported.
- EX/MEM register loads RegwriteE, MemwriteE, ResultSrcE, ALUResultE, WriteDataE, RdE and pc_plus4E.
- Every registered output is forced to 0 combinationally while rst is low.

## Timing
- Reset: asynchronous clear of every EX/MEM field to 0. All M outputs read 0 while rst is low; PCSrcE reads 0.
- Reset asserted mid-stall or mid-operation clears immediately. After rst rises, the first rising edge with StallE low loads normally.
- Latency: an ID/EX value present before edge N appears on the M outputs after edge N (1 cycle).
- StallE high at an edge: all EX/MEM fields hold. The combinational outputs (PCSrcE, PCTargetE, ALUResultE) still track the inputs. The hazard unit owns redirect qualification during a stall.
- Forwarding from ALUResultM uses the value registered at the previous edge. A back-to-back dependency therefore sees the prior result with zero bubbles.
- No bubble insertion here: flush of the EX/MEM register is not supported. Bubbles enter via the ID/EX register (RegwriteE = MemwriteE = 0).

## Structure
- Shared package `pipeline_pkg` holds:
  - the ALU op constants (ALU_ADD through ALU_SRA)
  - the forwarding select constants (FWD_REG, FWD_WB, FWD_MEM)
  - XLEN/REGW defaults
- Decode and the hazard unit use the same package.
- One sub-module: `alu` (combinational; SrcA, SrcB, ALUControl in; Result, Zero out).
- The forwarding muxes, branch logic and EX/MEM register stay in execute_stage.

## Test plan
- Reset: drive rst=0 mid-run with RegwriteM=1 already loaded -> all M outputs 0 immediately. After release, first load: RD1E=5, immExtE=7, ALUSrcE=1, op add -> ALUResultM=12 one cycle later.
- Forwarding: RD1E=1, ForwardAE=10, ALUResultM=0x10, RD2E=3, ForwardBE=01, ResultW=0x20, op sub -> ALUResultE=0xFFFFFFF0, WriteDataM=0x20 next cycle.
- Branch: branchE=1, RD1E=RD2E=9, op sub, PCE=0x100, immExtE=0xFFFFFFF8 -> PCSrcE=1, PCTargetE=0xF8. With RD2E=8 -> PCSrcE=0.
- Stall: load ALUResultM=0x55, then StallE=1 for 3 cycles with new inputs (add 1+1) -> ALUResultM stays 0x55. Drop the stall -> 2 after the next edge.
- ALU corners: sra 0x80000000 by 4 -> 0xF8000000. slt 0xFFFFFFFF,1 -> 1. sltu same operands -> 0. sll by immExt=0x21 -> shift by 1. Op 1111 -> 0.
- Jump: JumpE=1, branchE=0, PCE=0x40, immExtE=0x20, pc_plus4E=0x44 -> PCSrcE=1, PCTargetE=0x60, pc_plus4M=0x44 next cycle.
